corr_peak_detect: RTL and testbench

- Streaming consumer of the correlator's output: accepts one correlation result per cycle, indexed 0..NUM_LAGS-1.
- Tracks the maximum and reports its index and signed lag relative to zero-delay (centre index). The lag is the inter-channel delay estimate.
- Sits between the correlation engine and the top-level control FSM; one report per frame.

---
 rtl/corr_peak_detect.sv | 146 ++++++++++++++
 tb/tb_corr_peak_detect.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/corr_peak_detect.sv
// corr_peak_detect
//   Consumes one frame of correlator output (NUM_LAGS signed samples, index
//   0..NUM_LAGS-1) and reports where the maximum sits. The signed lag is
//   measured from the centre index, so it is the inter-channel delay estimate.
//
// Ports
//   clk, reset_n     system clock (rising edge), async active-low reset
//   start            arms a new frame (honoured only in IDLE)
//   in_valid/in_data/in_last/in_ready
//                    sample stream; a sample is taken on in_valid && in_ready
//   peak_valid       result held until peak_ack
//   peak_index       index of the first occurrence of the maximum
//   peak_lag         peak_index - (NUM_LAGS-1)/2, two's complement
//   peak_value       maximum sample value
//   length_err       frame did not end exactly at index NUM_LAGS-1
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | waiting for start; samples not accepted
// SCAN   | accepting samples, tracking running maximum
// REPORT | result presented on peak_*, waiting for peak_ack

module corr_peak_detect #(
    parameter int DATA_W   = 20,
    parameter int NUM_LAGS = 3999,
    parameter int IDX_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic                     peak_valid,
    input  logic                     peak_ack,
    output logic        [IDX_W-1:0]  peak_index,
    output logic signed [IDX_W:0]    peak_lag,
    output logic signed [DATA_W-1:0] peak_value,
    output logic                     length_err
);

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    localparam logic        [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_LAGS - 1);
    localparam logic        [IDX_W:0]    HALF     = (IDX_W + 1)'((NUM_LAGS - 1) / 2);
    localparam logic signed [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W - 1){1'b0}}};

    state_t                     state_q, state_d;
    logic        [IDX_W-1:0]    count_q, count_d;
    logic signed [DATA_W-1:0]   best_value_q, best_value_d;
    logic        [IDX_W-1:0]    best_index_q, best_index_d;
    logic        [IDX_W-1:0]    peak_index_q, peak_index_d;
    logic signed [IDX_W:0]      peak_lag_q, peak_lag_d;
    logic signed [DATA_W-1:0]   peak_value_q, peak_value_d;
    logic                       length_err_q, length_err_d;

    logic                       accept;
    logic                       at_last;
    logic                       better;
    logic signed [DATA_W-1:0]   cand_value;
    logic        [IDX_W-1:0]    cand_index;

    assign accept     = in_valid && (state_q == SCAN);
    assign at_last    = (count_q == LAST_IDX);
    // Strict compare so ties keep the earliest index.
    assign better     = (in_data > best_value_q);
    assign cand_value = better ? in_data : best_value_q;
    assign cand_index = better ? count_q : best_index_q;

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        best_value_d = best_value_q;
        best_index_d = best_index_q;
        peak_index_d = peak_index_q;
        peak_lag_d   = peak_lag_q;
        peak_value_d = peak_value_q;
        length_err_d = length_err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = SCAN;
                    count_d      = '0;
                    best_value_d = MOST_NEG;
                    best_index_d = '0;
                    length_err_d = 1'b0;
                end
            end
            SCAN: begin
                if (accept) begin
                    best_value_d = cand_value;
                    best_index_d = cand_index;
                    if (!at_last) begin
                        count_d = count_q + 1'b1;
                    end
                    if (in_last || at_last) begin
                        state_d      = REPORT;
                        peak_value_d = cand_value;
                        peak_index_d = cand_index;
                        peak_lag_d   = {1'b0, cand_index} - HALF;
                        // Early in_last or missing in_last at the final index.
                        length_err_d = in_last ^ at_last;
                    end
                end
            end
            REPORT: begin
                if (peak_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            count_q      <= '0;
            best_value_q <= MOST_NEG;
            best_index_q <= '0;
            peak_index_q <= '0;
            peak_lag_q   <= '0;
            peak_value_q <= '0;
            length_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            best_value_q <= best_value_d;
            best_index_q <= best_index_d;
            peak_index_q <= peak_index_d;
            peak_lag_q   <= peak_lag_d;
            peak_value_q <= peak_value_d;
            length_err_q <= length_err_d;
        end
    end

    assign in_ready   = (state_q == SCAN);
    assign peak_valid = (state_q == REPORT);
    assign peak_index = peak_index_q;
    assign peak_lag   = peak_lag_q;
    assign peak_value = peak_value_q;
    assign length_err = length_err_q;

endmodule

// File: tb/tb_corr_peak_detect.sv
// Bench for corr_peak_detect: a small NUM_LAGS=7 instance for the directed
// frames and a default-size instance for the centre-lag case. Expected
// reports are queued by the stimulus and popped by per-instance monitors.

module tb_corr_peak_detect;

    localparam int DW = 20;
    localparam int IW = 12;
    localparam int NB = 3999;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    logic                 a_start, a_valid, a_last, a_ack;
    logic signed [DW-1:0] a_data;
    logic                 a_ready, a_pvalid, a_err;
    logic        [IW-1:0] a_idx;
    logic signed [IW:0]   a_lag;
    logic signed [DW-1:0] a_val;

    logic                 b_start, b_valid, b_last, b_ack;
    logic signed [DW-1:0] b_data;
    logic                 b_ready, b_pvalid, b_err;
    logic        [IW-1:0] b_idx;
    logic signed [IW:0]   b_lag;
    logic signed [DW-1:0] b_val;

    corr_peak_detect #(.DATA_W(DW), .NUM_LAGS(7), .IDX_W(IW)) u_small (
        .clk(clk), .reset_n(reset_n), .start(a_start),
        .in_valid(a_valid), .in_data(a_data), .in_last(a_last), .in_ready(a_ready),
        .peak_valid(a_pvalid), .peak_ack(a_ack), .peak_index(a_idx),
        .peak_lag(a_lag), .peak_value(a_val), .length_err(a_err)
    );

    corr_peak_detect #(.DATA_W(DW), .NUM_LAGS(NB), .IDX_W(IW)) u_full (
        .clk(clk), .reset_n(reset_n), .start(b_start),
        .in_valid(b_valid), .in_data(b_data), .in_last(b_last), .in_ready(b_ready),
        .peak_valid(b_pvalid), .peak_ack(b_ack), .peak_index(b_idx),
        .peak_lag(b_lag), .peak_value(b_val), .length_err(b_err)
    );

    typedef struct {
        int idx;
        int val;
        int lag;
        int err;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   fails  = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors: pop on the first cycle of peak_valid, then keep comparing
    // every cycle it stays high so any drift in the held result shows up.
    logic a_prev = 1'b0;
    exp_t a_cur  = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (!reset_n) begin
            a_prev = 1'b0;
        end else begin
            if (a_pvalid && !a_prev) begin
                if (q_a.size() == 0) chk("a_unexpected_report", 1, 0);
                else a_cur = q_a.pop_front();
            end
            if (a_pvalid) begin
                chk("a_peak_index", int'(a_idx), a_cur.idx);
                chk("a_peak_value", int'(a_val), a_cur.val);
                chk("a_peak_lag",   int'(a_lag), a_cur.lag);
                chk("a_length_err", int'(a_err), a_cur.err);
            end
            a_prev = a_pvalid;
        end
    end

    logic b_prev = 1'b0;
    exp_t b_cur  = '{0, 0, 0, 0};
    always @(negedge clk) begin
        if (!reset_n) begin
            b_prev = 1'b0;
        end else begin
            if (b_pvalid && !b_prev) begin
                if (q_b.size() == 0) chk("b_unexpected_report", 1, 0);
                else b_cur = q_b.pop_front();
            end
            if (b_pvalid) begin
                chk("b_peak_index", int'(b_idx), b_cur.idx);
                chk("b_peak_value", int'(b_val), b_cur.val);
                chk("b_peak_lag",   int'(b_lag), b_cur.lag);
                chk("b_length_err", int'(b_err), b_cur.err);
            end
            b_prev = b_pvalid;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic a_start_frame;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
    endtask

    task automatic a_send(input int d, input bit last, input int gap);
        a_data  = d[DW-1:0];
        a_valid = 1'b1;
        a_last  = last;
        tick();
        a_valid = 1'b0;
        a_last  = 1'b0;
        repeat (gap) tick();
    endtask

    // Sends a complete frame; the cycle after the final sample must show the
    // report with intake closed.
    task automatic a_frame(input int v[$], input int last_at, input int gap);
        for (int i = 0; i < v.size(); i++) begin
            a_send(v[i], (i == last_at), (i == v.size() - 1) ? 0 : gap);
        end
        chk("a_latency_valid", int'(a_pvalid), 1);
        chk("a_report_ready",  int'(a_ready), 0);
    endtask

    task automatic a_acknowledge(input int delay);
        repeat (delay) tick();
        chk("a_valid_before_ack", int'(a_pvalid), 1);
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("a_valid_after_ack", int'(a_pvalid), 0);
        chk("a_idle_ready",      int'(a_ready), 0);
    endtask

    task automatic a_check_zero(input string tag);
        chk({tag, "_valid"}, int'(a_pvalid), 0);
        chk({tag, "_ready"}, int'(a_ready), 0);
        chk({tag, "_index"}, int'(a_idx), 0);
        chk({tag, "_value"}, int'(a_val), 0);
        chk({tag, "_lag"},   int'(a_lag), 0);
        chk({tag, "_err"},   int'(a_err), 0);
    endtask

    int f_base[$]  = '{3, -1, 9, 4, 9, 0, 2};
    int f_negpk[$] = '{-5, -5, -5, -5, -5, -5, -2};
    int f_neg[$]   = '{-5, -5, -5, -5, -5, -5, -5};
    int f_short[$] = '{1, 2, 8, 3};
    int f_ramp[$]  = '{0, 1, 2, 3, 4, 5, 6};
    int f_one[$]   = '{-7};

    initial begin
        reset_n = 1'b0;
        a_start = 0; a_valid = 0; a_last = 0; a_ack = 0; a_data = '0;
        b_start = 0; b_valid = 0; b_last = 0; b_ack = 0; b_data = '0;
        repeat (2) tick();
        a_check_zero("reset");
        chk("reset_b_valid", int'(b_pvalid), 0);
        reset_n = 1'b1;
        tick();

        // Basic frame: first 9 wins over the later tie.
        q_a.push_back('{2, 9, -1, 0});
        a_start_frame();
        a_frame(f_base, 6, 0);
        a_acknowledge(0);

        q_a.push_back('{6, -2, 3, 0});
        a_start_frame();
        a_frame(f_negpk, 6, 0);
        a_acknowledge(0);

        q_a.push_back('{0, -5, -3, 0});
        a_start_frame();
        a_frame(f_neg, 6, 0);
        a_acknowledge(0);

        // Early in_last.
        q_a.push_back('{2, 8, -1, 1});
        a_start_frame();
        a_frame(f_short, 3, 0);
        a_acknowledge(0);

        // Full length without in_last.
        q_a.push_back('{6, 6, 3, 1});
        a_start_frame();
        a_frame(f_ramp, -1, 0);
        a_acknowledge(0);

        // Single sample carrying in_last.
        q_a.push_back('{0, -7, -3, 1});
        a_start_frame();
        a_frame(f_one, 0, 0);
        a_acknowledge(0);

        // Gapped intake, delayed ack, samples offered during REPORT.
        q_a.push_back('{2, 9, -1, 0});
        a_start_frame();
        a_frame(f_base, 6, 1);
        a_data  = 20'sd100;
        a_valid = 1'b1;
        a_last  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("a_report_ignores_samples", int'(a_ready), 0);
            tick();
        end
        a_valid = 1'b0;
        a_last  = 1'b0;
        a_acknowledge(0);

        // Reset in the middle of a frame.
        a_start_frame();
        a_send(50, 1'b0, 0);
        a_send(60, 1'b0, 0);
        a_send(70, 1'b0, 0);
        chk("abort_ready_before", int'(a_ready), 1);
        #2 reset_n = 1'b0;
        #1 a_check_zero("abort");
        tick();
        reset_n = 1'b1;
        tick();
        q_a.push_back('{2, 9, -1, 0});
        a_start_frame();
        a_frame(f_base, 6, 0);
        a_acknowledge(0);

        // peak_ack in IDLE, then start in mid-SCAN: both ignored.
        a_ack = 1'b1;
        tick();
        a_ack = 1'b0;
        chk("idle_ack_valid", int'(a_pvalid), 0);
        chk("idle_ack_ready", int'(a_ready), 0);
        q_a.push_back('{2, 9, -1, 0});
        a_start_frame();
        a_send(3, 1'b0, 0);
        a_send(-1, 1'b0, 0);
        a_send(9, 1'b0, 0);
        a_start_frame();
        chk("scan_start_ready", int'(a_ready), 1);
        a_send(4, 1'b0, 0);
        a_send(9, 1'b0, 0);
        a_send(0, 1'b0, 0);
        a_send(2, 1'b1, 0);
        chk("scan_start_latency", int'(a_pvalid), 1);
        a_acknowledge(2);

        // Default size: peak at the centre gives zero lag.
        q_b.push_back('{1999, 500, 0, 0});
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int i = 0; i < NB; i++) begin
            b_data  = (i == 1999) ? 20'sd500 : 20'sd0;
            b_valid = 1'b1;
            b_last  = (i == NB - 1);
            tick();
        end
        b_valid = 1'b0;
        b_last  = 1'b0;
        chk("b_latency_valid", int'(b_pvalid), 1);
        repeat (2) tick();
        b_ack = 1'b1;
        tick();
        b_ack = 1'b0;
        chk("b_valid_after_ack", int'(b_pvalid), 0);

        repeat (3) tick();
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
